blake2_msg_packer: RTL and testbench

Parametric message-block assembler in front of the BLAKE2 compression core, covering both BLAKE2s (W=32) and BLAKE2b (W=64).
- Accepts a multi-byte valid/ready input stream and packs it little-endian into BB-byte blocks.
- Zero-pads the final block and tracks the running byte counter t.
- Marks first/last blocks; "last" is decided by look-ahead on the next input beat.
- Optionally prepends the zero-padded secret-key block.

---
 rtl/blake2_pkg.sv | 23 ++
 rtl/blake2_byte_packer.sv | 26 ++
 rtl/blake2_msg_packer.sv | 170 +++++++++++++++++
 tb/tb_blake2_msg_packer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_pkg.sv
// Shared state encoding and size helpers for the BLAKE2 message-block packer.
package blake2_pkg;

    localparam int W_BLAKE2S = 32;
    localparam int W_BLAKE2B = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_KEY = 2'd1,
        FILL     = 2'd2,
        EMIT     = 2'd3
    } state_e;

    function automatic int blk_bytes(input int w);
        return 2 * w;
    endfunction

    // One extra bit so a completely full block (offset == BB) is representable.
    function automatic int ptr_bits(input int w);
        return $clog2(2 * w) + 1;
    endfunction

endpackage

// File: rtl/blake2_byte_packer.sv
// Writes the first nb_i bytes of an IN_B-byte beat into a BB-byte buffer at byte offset off_i.
module blake2_byte_packer
    import blake2_pkg::*;
#(
    parameter int BB   = 64,
    parameter int IN_B = 4,
    parameter int PW   = ptr_bits(BB / 2),
    parameter int NBW  = $clog2(IN_B + 1)
) (
    input  logic [8*BB-1:0]   buf_i,
    input  logic [PW-1:0]     off_i,
    input  logic [8*IN_B-1:0] data_i,
    input  logic [NBW-1:0]    nb_i,
    output logic [8*BB-1:0]   buf_o
);

    always_comb begin
        buf_o = buf_i;
        for (int j = 0; j < IN_B; j++) begin
            if ((j < int'(nb_i)) && (int'(off_i) + j < BB)) begin
                buf_o[8*(int'(off_i) + j) +: 8] = data_i[8*j +: 8];
            end
        end
    end

endmodule

// File: rtl/blake2_msg_packer.sv
// BLAKE2 message-block assembler: packs a byte stream into zero-padded BB-byte blocks with t/first/last.
// Define BLAKE2_KEY_EN to add the kk_i/key_i ports and the prepended key block.
module blake2_msg_packer
    import blake2_pkg::*;
#(
    parameter int W    = W_BLAKE2S,
    parameter int IN_B = 4,
    localparam int BB  = blk_bytes(W),
    localparam int PW  = ptr_bits(W),
    localparam int NBW = $clog2(IN_B + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
`ifdef BLAKE2_KEY_EN
    input  logic [7:0]        kk_i,
    input  logic [8*W-1:0]    key_i,
`endif
    input  logic              in_v_i,
    output logic              in_rdy_o,
    input  logic [8*IN_B-1:0] in_data_i,
    input  logic [NBW-1:0]    in_nb_i,
    input  logic              in_last_i,
    output logic              blk_v_o,
    input  logic              blk_rdy_i,
    output logic [8*BB-1:0]   blk_o,
    output logic              blk_first_o,
    output logic              blk_last_o,
    output logic [2*W-1:0]    t_o,
    output logic              busy_o
);

    if ((W != W_BLAKE2S) && (W != W_BLAKE2B)) begin : g_bad_w
        $error("blake2_msg_packer: W must be 32 or 64");
    end

    state_e            state_q;
    logic [8*BB-1:0]   buf_q;
    logic [8*BB-1:0]   pack_d;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic [2*W-1:0]    t_q;
    logic [2*W-1:0]    t_d;
    logic              full_q;
    logic              first_q;
    logic              last_q;
    logic              blk_v_q;
    logic              busy_q;
    logic              nb_zero_last;

    // An empty closing beat is still taken while the buffer is full; it just marks the block last.
    assign nb_zero_last = in_v_i & in_last_i & (in_nb_i == '0);
    assign in_rdy_o     = (state_q == FILL) & (~full_q | nb_zero_last);
    assign ptr_d        = ptr_q + PW'(in_nb_i);
    assign t_d          = t_q + (2*W)'(in_nb_i);

    blake2_byte_packer #(
        .BB   (BB),
        .IN_B (IN_B),
        .PW   (PW),
        .NBW  (NBW)
    ) u_packer (
        .buf_i  (buf_q),
        .off_i  (ptr_q),
        .data_i (in_data_i),
        .nb_i   (in_nb_i),
        .buf_o  (pack_d)
    );

`ifdef BLAKE2_KEY_EN
    logic [8*BB-1:0] key_blk_d;

    always_comb begin
        key_blk_d = '0;
        for (int k = 0; k < W; k++) begin
            if (k < int'(kk_i)) begin
                key_blk_d[8*k +: 8] = key_i[8*k +: 8];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            ptr_q   <= '0;
            t_q     <= '0;
            full_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            blk_v_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        buf_q   <= '0;
                        ptr_q   <= '0;
                        t_q     <= '0;
                        full_q  <= 1'b0;
                        first_q <= 1'b1;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef BLAKE2_KEY_EN
                        state_q <= (kk_i != 8'd0) ? LOAD_KEY : FILL;
`else
                        state_q <= FILL;
`endif
                    end
                end
`ifdef BLAKE2_KEY_EN
                LOAD_KEY: begin
                    buf_q   <= key_blk_d;
                    ptr_q   <= PW'(BB);
                    t_q     <= t_q + (2*W)'(BB);
                    full_q  <= 1'b1;
                    state_q <= FILL;
                end
`endif
                FILL: begin
                    if (in_v_i) begin
                        if (!full_q) begin
                            buf_q <= pack_d;
                            ptr_q <= ptr_d;
                            t_q   <= t_d;
                            if (in_last_i) begin
                                last_q  <= 1'b1;
                                blk_v_q <= 1'b1;
                                state_q <= EMIT;
                            end else if (ptr_d == PW'(BB)) begin
                                full_q <= 1'b1;
                            end
                        end else begin
                            // Full block: the pending beat decides whether it is the last one.
                            last_q  <= nb_zero_last;
                            blk_v_q <= 1'b1;
                            state_q <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (blk_rdy_i) begin
                        blk_v_q <= 1'b0;
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            buf_q   <= '0;
                            ptr_q   <= '0;
                            full_q  <= 1'b0;
                            state_q <= FILL;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign blk_v_o     = blk_v_q;
    assign blk_o       = buf_q;
    assign blk_first_o = first_q;
    assign blk_last_o  = last_q;
    assign t_o         = t_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_blake2_msg_packer.sv
// Randomized bench for blake2_msg_packer (W=32, IN_B=4) against a block-level reference model.
module tb_blake2_msg_packer;
    import blake2_pkg::*;

    localparam int W    = W_BLAKE2S;
    localparam int IN_B = 4;
    localparam int BB   = blk_bytes(W);
    localparam int NBW  = $clog2(IN_B + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic              in_v_i;
    logic              in_rdy_o;
    logic [8*IN_B-1:0] in_data_i;
    logic [NBW-1:0]    in_nb_i;
    logic              in_last_i;
    logic              blk_v_o;
    logic              blk_rdy_i;
    logic [8*BB-1:0]   blk_o;
    logic              blk_first_o;
    logic              blk_last_o;
    logic [2*W-1:0]    t_o;
    logic              busy_o;
`ifdef BLAKE2_KEY_EN
    logic [7:0]        kk_i;
    logic [8*W-1:0]    key_i;
`endif

    blake2_msg_packer #(.W(W), .IN_B(IN_B)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
`ifdef BLAKE2_KEY_EN
        .kk_i        (kk_i),
        .key_i       (key_i),
`endif
        .in_v_i      (in_v_i),
        .in_rdy_o    (in_rdy_o),
        .in_data_i   (in_data_i),
        .in_nb_i     (in_nb_i),
        .in_last_i   (in_last_i),
        .blk_v_o     (blk_v_o),
        .blk_rdy_i   (blk_rdy_i),
        .blk_o       (blk_o),
        .blk_first_o (blk_first_o),
        .blk_last_o  (blk_last_o),
        .t_o         (t_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 2;  // 0 random, 1 held low, 2 held high

    logic [7:0]      msg[$];
    logic [7:0]      key_b[W];
    logic [8*BB-1:0] exp_blk[$];
    logic            exp_first[$];
    logic            exp_last[$];
    logic [2*W-1:0]  exp_t[$];
    logic [8*BB-1:0] obs_blk[$];
    logic            obs_first[$];
    logic            obs_last[$];
    logic [2*W-1:0]  obs_t[$];

    task automatic chk(input string tag, input logic [8*BB-1:0] obs, input logic [8*BB-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core-side ready: changes just after the rising edge.
    initial begin
        blk_rdy_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       blk_rdy_i = ($urandom_range(0, 2) != 0);
                1:       blk_rdy_i = 1'b0;
                default: blk_rdy_i = 1'b1;
            endcase
        end
    end

    // A block is taken at the next rising edge if valid and ready are both high here.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && blk_v_o && blk_rdy_i) begin
                obs_blk.push_back(blk_o);
                obs_first.push_back(blk_first_o);
                obs_last.push_back(blk_last_o);
                obs_t.push_back(t_o);
            end
        end
    end

    // Reference: key block (if any), then the message cut into BB-byte chunks, zero padded.
    task automatic build_expect(input int kk);
        int len, nblk, n;
        logic [8*BB-1:0] b;
        logic [2*W-1:0]  t;
        exp_blk.delete(); exp_first.delete(); exp_last.delete(); exp_t.delete();
        len  = msg.size();
        t    = '0;
        nblk = (len + BB - 1) / BB;
        if (nblk == 0 && kk == 0) nblk = 1;
        if (kk > 0) begin
            b = '0;
            for (int i = 0; i < kk; i++) b[8*i +: 8] = key_b[i];
            t = t + BB;
            exp_blk.push_back(b); exp_first.push_back(1'b1);
            exp_last.push_back(nblk == 0); exp_t.push_back(t);
        end
        for (int k = 0; k < nblk; k++) begin
            n = (len - k*BB < BB) ? len - k*BB : BB;
            b = '0;
            for (int i = 0; i < n; i++) b[8*i +: 8] = msg[k*BB + i];
            t = t + n;
            exp_blk.push_back(b); exp_first.push_back(kk == 0 && k == 0);
            exp_last.push_back(k == nblk - 1); exp_t.push_back(t);
        end
    endtask

    task automatic fill_rand(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    task automatic do_start(input int kk);
        @(negedge clk);
        start_i = 1'b1;
`ifdef BLAKE2_KEY_EN
        kk_i = 8'(kk);
        for (int k = 0; k < W; k++) key_i[8*k +: 8] = key_b[k];
`else
        if (kk != 0) $display("note: key length %0d ignored without key support", kk);
`endif
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_beats(input bit tail, input int pause_at);
        int  pos, bi, rem, nb, cyc;
        bit  last, done;
        pos = 0; bi = 0; done = 0;
        while (!done) begin
            rem = msg.size() - pos;
            if (rem > IN_B || (rem == IN_B && tail)) begin
                nb = IN_B; last = 1'b0;
            end else begin
                nb = rem; last = 1'b1;
            end
            if (pause_at > 0 && bi == pause_at) begin
                in_v_i = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("no_early_emit", blk_v_o, 0);
                end
            end else if (rdy_mode == 0 && $urandom_range(0, 3) == 0) begin
                in_v_i = 1'b0;
                @(negedge clk);
            end
            in_v_i    = 1'b1;
            in_nb_i   = NBW'(nb);
            in_last_i = last;
            for (int j = 0; j < IN_B; j++)
                in_data_i[8*j +: 8] = (j < nb) ? msg[pos + j] : 8'($urandom);
            cyc = 0;
            #1;
            while (!in_rdy_o && cyc < 300) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            chk("beat_accept", in_rdy_o, 1);
            @(negedge clk);
            pos += nb;
            bi++;
            if (last) begin
                chk("last_latency", blk_v_o, 1);
                in_v_i = 1'b0;
                done   = 1;
            end
        end
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while ((obs_blk.size() < exp_blk.size() || busy_o) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("block_count", obs_blk.size(), exp_blk.size());
        chk("idle_after", busy_o, 0);
    endtask

    task automatic compare(input string name);
        int n;
        n = (obs_blk.size() < exp_blk.size()) ? obs_blk.size() : exp_blk.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_blk%0d", name, i),   obs_blk[i],   exp_blk[i]);
            chk($sformatf("%s_first%0d", name, i), obs_first[i], exp_first[i]);
            chk($sformatf("%s_last%0d", name, i),  obs_last[i],  exp_last[i]);
            chk($sformatf("%s_t%0d", name, i),     obs_t[i],     exp_t[i]);
        end
    endtask

    task automatic run_msg(input string name, input int kk, input bit tail, input int pause_at);
        build_expect(kk);
        obs_blk.delete(); obs_first.delete(); obs_last.delete(); obs_t.delete();
        do_start(kk);
        send_beats(tail, pause_at);
        wait_done();
        compare(name);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_blk_v"}, blk_v_o, 0);
        chk({name, "_blk"},   blk_o, 0);
        chk({name, "_first"}, blk_first_o, 0);
        chk({name, "_last"},  blk_last_o, 0);
        chk({name, "_t"},     t_o, 0);
        chk({name, "_busy"},  busy_o, 0);
        chk({name, "_rdy"},   in_rdy_o, 0);
    endtask

    initial begin
        logic [8*BB-1:0] snap_b;
        logic [2*W-1:0]  snap_t;
        int len, kk;
        bit tail;

        reset = 1'b1; start_i = 1'b0;
        in_v_i = 1'b1; in_last_i = 1'b1; in_nb_i = '0; in_data_i = '0;
        for (int k = 0; k < W; k++) key_b[k] = 8'($urandom);
`ifdef BLAKE2_KEY_EN
        kk_i = '0; key_i = '0;
`endif
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rdy", in_rdy_o, 0);
        in_v_i = 1'b0;

        // Empty message, then "abc".
        fill_rand(0);
        run_msg("empty", 0, 1'b0, 0);
        msg.delete(); msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg("abc", 0, 1'b0, 0);
        chk("abc_const", obs_blk[0], 512'h636261);
        chk("abc_t3", obs_t[0], 3);

        // Exactly one block, closed on the data beat and then by an empty beat.
        fill_rand(64);
        run_msg("b64", 0, 1'b0, 0);
        run_msg("b64tail", 0, 1'b1, 16);

        // 65 bytes: first block waits for the 17th beat.
        fill_rand(65);
        run_msg("b65", 0, 1'b0, 16);

        // Backpressure on a single-block message.
        fill_rand(64);
        build_expect(0);
        obs_blk.delete(); obs_first.delete(); obs_last.delete(); obs_t.delete();
        rdy_mode = 1;
        @(negedge clk);
        do_start(0);
        send_beats(1'b0, 0);
        snap_b = blk_o;
        snap_t = t_o;
        in_v_i = 1'b1; in_nb_i = NBW'(IN_B); in_last_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_v", blk_v_o, 1);
            chk("stall_blk", blk_o, snap_b);
            chk("stall_t", t_o, snap_t);
            chk("stall_rdy", in_rdy_o, 0);
        end
        in_v_i = 1'b0;
        rdy_mode = 2;
        wait_done();
        compare("stall");

        // Reset in the middle of filling.
        fill_rand(64);
        do_start(0);
        in_v_i = 1'b1; in_nb_i = NBW'(IN_B); in_last_i = 1'b0; in_data_i = 32'hdeadbeef;
        repeat (5) @(negedge clk);
        chk("fill_busy", busy_o, 1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        in_v_i = 1'b0;
        @(negedge clk);

`ifdef BLAKE2_KEY_EN
        for (int k = 0; k < W; k++) key_b[k] = 8'(k);
        fill_rand(0);
        run_msg("key32", 32, 1'b0, 0);
        chk("key32_t", obs_t[0], 64);
`endif

        // Randomized messages with random core backpressure.
        rdy_mode = 0;
        for (int m = 0; m < 12; m++) begin
            len  = ($urandom_range(0, 1) != 0) ? 4 * $urandom_range(0, 50) : $urandom_range(0, 200);
            tail = 1'($urandom_range(0, 1));
            kk   = 0;
`ifdef BLAKE2_KEY_EN
            for (int k = 0; k < W; k++) key_b[k] = 8'($urandom);
            if ($urandom_range(0, 1) != 0) kk = $urandom_range(1, W);
`endif
            fill_rand(len);
            run_msg($sformatf("rnd%0d", m), kk, tail, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
